// File: rtl/mux_rr_arbiter_4.sv
// mux_rr_arbiter_4
//   Round-robin arbiter and output register for the shared 4-input operand mux
//   of the matrix multiplier. One winner per beat drives the mux select. Its
//   word is registered and offered downstream on a valid/ready handshake.
//
//   Optional feature macro: MUX_ARB_BURST_EN
//     Defined:   the previous winner may keep the mux for up to MAX_BURST
//                consecutive beats before normal rotation resumes.
//     Undefined: pure round-robin, rotating after every beat. MAX_BURST unused.
module mux_rr_arbiter_4 #(
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  output logic [3:0]        ack,
  output logic [1:0]        sel,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
);

  // EMPTY: out_data holds nothing to offer. FULL: out_data is valid.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        last;      // index of the most recent winner
  logic [1:0]        rr_win;    // plain round-robin choice
  logic [1:0]        win;       // final choice, after optional burst hold
  logic              load;      // a word is captured at the next edge
  logic [DATA_W-1:0] win_data;

  // The register can take a new word when it is empty or being drained.
  assign load = ((state == EMPTY) || out_ready) && (|req);

  // Search order last+1, last+2, last+3, last; the nearest requester wins.
  always_comb begin
    // NOTE: assigning a default before any conditional write keeps every path
    // covered, so no latch is inferred.
    rr_win = last;
    for (int k = 4; k >= 1; k--) begin
      if (req[last + 2'(k)]) rr_win = last + 2'(k);
    end
  end

`ifdef MUX_ARB_BURST_EN
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  logic [CNT_W-1:0] burst_cnt;   // extra beats already given to last
  logic             held;        // last refers to a real grant since reset
  logic             burst_hold;

  // The previous winner keeps the mux while it still asks and has budget left.
  // Until the first grant after reset, last=3 is only a rotation seed.
  assign burst_hold = held && req[last] && (int'(burst_cnt) < MAX_BURST - 1);
  assign win        = burst_hold ? last : rr_win;

  // Burst counter: counts held beats and clears whenever rotation decides.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt <= '0;
      held      <= 1'b0;
    end else if (load) begin
      held      <= 1'b1;
      burst_cnt <= burst_hold ? (burst_cnt + CNT_W'(1)) : '0;
    end
  end
`else
  logic unused_max_burst;

  assign win              = rr_win;
  assign unused_max_burst = (MAX_BURST > 0);
`endif

  // Operand mux driven by the current winner.
  always_comb begin
    win_data = in0;
    case (win)
      2'd1:    win_data = in1;
      2'd2:    win_data = in2;
      2'd3:    win_data = in3;
      default: win_data = in0;
    endcase
  end

  // Mealy grant: the winner is acknowledged in the cycle its word is taken.
  // Forced low while reset is held, since the empty register would otherwise
  // appear ready to load.
  always_comb begin
    ack = '0;
    if (rst_n && load) ack[win] = 1'b1;
  end

  // Output FSM next state.
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (load) state_nxt = FULL;
      FULL:    if (out_ready && !(|req)) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // Output FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      // NOTE: non-blocking assignment, so every register samples values from
      // before the edge regardless of block ordering.
      state <= state_nxt;
    end
  end

  // Data, select and rotation pointer are updated only when a word is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: out_data is reset because its cleared value is visible on the
      // port; a wide datapath register nobody observes could skip reset.
      out_data <= '0;
      sel      <= 2'd0;
      last     <= 2'd3;
    end else if (load) begin
      out_data <= win_data;
      sel      <= win;
      last     <= win;
    end
  end

  assign out_valid = (state == FULL);

endmodule
